// File: rtl/rf_wb_arbiter.sv
// Shares the RegFile write port between pipeline writeback (fixed priority) and
// a 1-entry MDU result buffer; tracks outstanding MDU destinations for decode.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_wr,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        hazard,
    output logic        stall_req,
    output logic [31:0] pending,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic              vld_p1;
    logic [4:0]        addr_p1;
    logic [31:0]       data_p1;
    logic [CNT_W-1:0]  starve_cnt;
    logic              stall_q;
    logic [31:0]       pend_q;
    logic [31:0]       pend_next;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;
    logic              wb_own;
    logic              buf_write;
    logic              buf_leave;
    logic              starved;
    logic              accept;

    // Writes to r0 are dropped, so a WB request to r0 leaves the port free.
    assign wb_own    = wb_wr & (wb_addr != 5'd0);
    assign buf_leave = vld_p1 & ~wb_own;
    assign buf_write = buf_leave & (addr_p1 != 5'd0);
    assign starved   = vld_p1 & wb_own;

    assign md_ready  = ~vld_p1 & ~reset;
    assign accept    = md_valid & md_ready;

    always_comb begin
        rf_wr   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (wb_own) begin
            rf_wr   = ~reset;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (buf_write) begin
            rf_wr   = ~reset;
            rf_addr = addr_p1;
            rf_data = data_p1;
        end
    end

    // An issue and a drain on the same register in one cycle leave it pending.
    always_comb begin
        set_mask  = iss_valid ? (32'd1 << iss_addr) : 32'd0;
        clr_mask  = buf_write ? (32'd1 << addr_p1) : 32'd0;
        pend_next = ((pend_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    assign pending   = pend_q;
    assign hazard    = pend_q[rs_addr] | pend_q[rt_addr] | pend_q[rd_addr];
    assign stall_req = stall_q;

    // ---- stage p1: holding buffer, scoreboard and starvation control ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            pend_q     <= 32'd0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (buf_leave)
                vld_p1 <= 1'b0;
            pend_q     <= pend_next;
            starve_cnt <= starved ? sat_inc(starve_cnt) : '0;
            stall_q    <= starved & (stall_q | (starve_cnt >= LIMIT_M1));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= md_addr;
            data_p1 <= md_data;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: RegFile writes are matched in order
// against a queue of expected (addr, data) pairs; other outputs checked inline.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        hazard;
    logic        stall_req;
    logic [31:0] pending;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .hazard(hazard), .stall_req(stall_req), .pending(pending),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic mon();
        wr_t e;
        if (rf_wr !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("rf_unexpected_wr", 32'(rf_wr), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", 32'(rf_addr), 32'(e.a));
                chk("sb_data", rf_data, e.d);
            end
        end
    endtask

    // Settle to the middle of the cycle and match any RegFile write.
    task automatic mid();
        @(negedge clk);
        mon();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_wr = 0; wb_addr = 0; wb_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        iss_valid = 0; iss_addr = 0;
        rs_addr = 0; rt_addr = 0; rd_addr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1;
        #1;

        // 1: reset with both requesters active
        md_valid = 1; md_addr = 5'd6; md_data = 32'h6666_6666;
        wb_wr = 1; wb_addr = 5'd3; wb_data = 32'h3333_3333;
        mid();
        chk("rst0_rf_wr", 32'(rf_wr), 32'd0);
        chk("rst0_md_ready", 32'(md_ready), 32'd0);
        nxt();
        mid();
        chk("rst1_rf_wr", 32'(rf_wr), 32'd0);
        chk("rst1_md_ready", 32'(md_ready), 32'd0);
        chk("rst1_pending", pending, 32'd0);
        chk("rst1_stall", 32'(stall_req), 32'd0);
        nxt();
        reset = 0;
        idle();
        mid();
        chk("rel_md_ready", 32'(md_ready), 32'd1);
        chk("rel_pending", pending, 32'd0);
        chk("rel_rf_wr", 32'(rf_wr), 32'd0);
        nxt();

        // 2: issue r5, result arrives in cycle 3, written in cycle 4
        iss_valid = 1; iss_addr = 5'd5; rs_addr = 5'd5;
        mid();
        chk("t2c0_hazard", 32'(hazard), 32'd0);
        nxt();
        iss_valid = 0; iss_addr = 0;
        for (int c = 1; c <= 2; c++) begin
            mid();
            chk("t2_pending5", 32'(pending[5]), 32'd1);
            chk("t2_hazard", 32'(hazard), 32'd1);
            nxt();
        end
        md_valid = 1; md_addr = 5'd5; md_data = 32'h1234_5678;
        push(5'd5, 32'h1234_5678);
        mid();
        chk("t2c3_md_ready", 32'(md_ready), 32'd1);
        chk("t2c3_rf_wr", 32'(rf_wr), 32'd0);
        chk("t2c3_hazard", 32'(hazard), 32'd1);
        nxt();
        md_valid = 0; md_addr = 0; md_data = 0;
        mid();
        chk("t2c4_rf_wr", 32'(rf_wr), 32'd1);
        chk("t2c4_md_ready", 32'(md_ready), 32'd0);
        chk("t2c4_pending5", 32'(pending[5]), 32'd1);
        chk("t2c4_hazard", 32'(hazard), 32'd1);
        nxt();
        mid();
        chk("t2c5_pending", pending, 32'd0);
        chk("t2c5_hazard", 32'(hazard), 32'd0);
        chk("t2c5_md_ready", 32'(md_ready), 32'd1);
        nxt();
        idle();

        // 3: buffered r7 starved by writeback to r3
        iss_valid = 1; iss_addr = 5'd7;
        nxt();
        iss_valid = 0; iss_addr = 0;
        md_valid = 1; md_addr = 5'd7; md_data = 32'h0000_0077;
        wb_wr = 1; wb_addr = 5'd3; wb_data = 32'h0000_000A;
        push(5'd3, 32'h0000_000A);
        mid();
        chk("t3h_rf_addr", 32'(rf_addr), 32'd3);
        nxt();
        md_valid = 0; md_addr = 0; md_data = 0;
        rt_addr = 5'd7;
        for (int s = 0; s < 4; s++) begin
            push(5'd3, 32'h0000_000A);
            mid();
            chk("t3_starved_md_ready", 32'(md_ready), 32'd0);
            chk("t3_starved_stall", 32'(stall_req), 32'd0);
            chk("t3_starved_rf_addr", 32'(rf_addr), 32'd3);
            nxt();
        end
        push(5'd3, 32'h0000_000A);
        mid();
        chk("t3s4_stall", 32'(stall_req), 32'd1);
        chk("t3s4_rf_data", rf_data, 32'h0000_000A);
        nxt();
        wb_wr = 0; wb_addr = 0; wb_data = 0;
        push(5'd7, 32'h0000_0077);
        mid();
        chk("t3s5_stall", 32'(stall_req), 32'd1);
        chk("t3s5_rf_wr", 32'(rf_wr), 32'd1);
        chk("t3s5_hazard", 32'(hazard), 32'd1);
        nxt();
        mid();
        chk("t3s6_stall", 32'(stall_req), 32'd0);
        chk("t3s6_pending", pending, 32'd0);
        chk("t3s6_md_ready", 32'(md_ready), 32'd1);
        nxt();
        idle();

        // 4: re-issue of r9 in the cycle its previous result drains
        iss_valid = 1; iss_addr = 5'd9;
        nxt();
        iss_valid = 0; iss_addr = 0;
        md_valid = 1; md_addr = 5'd9; md_data = 32'h0000_0099;
        push(5'd9, 32'h0000_0099);
        nxt();
        md_valid = 0; md_addr = 0; md_data = 0;
        iss_valid = 1; iss_addr = 5'd9;
        mid();
        chk("t4_rf_addr", 32'(rf_addr), 32'd9);
        nxt();
        iss_valid = 0; iss_addr = 0;
        mid();
        chk("t4_pending", pending, 32'h0000_0200);
        nxt();

        // 5: MDU result to r0 is discarded; issue to r0 is ignored
        md_valid = 1; md_addr = 5'd0; md_data = 32'h0000_DEAD;
        iss_valid = 1; iss_addr = 5'd0;
        mid();
        chk("t5a_md_ready", 32'(md_ready), 32'd1);
        nxt();
        idle();
        mid();
        chk("t5b_rf_wr", 32'(rf_wr), 32'd0);
        chk("t5b_md_ready", 32'(md_ready), 32'd0);
        chk("t5b_pending", pending, 32'h0000_0200);
        nxt();
        mid();
        chk("t5c_md_ready", 32'(md_ready), 32'd1);
        chk("t5c_pending", pending, 32'h0000_0200);
        nxt();
        md_valid = 1; md_addr = 5'd4; md_data = 32'h0000_0044;
        push(5'd4, 32'h0000_0044);
        nxt();
        md_valid = 0; md_addr = 0; md_data = 0;
        wb_wr = 1; wb_addr = 5'd0; wb_data = 32'h0000_0BAD;
        mid();
        chk("t5e_rf_wr", 32'(rf_wr), 32'd1);
        chk("t5e_rf_addr", 32'(rf_addr), 32'd4);
        chk("t5e_rf_data", rf_data, 32'h0000_0044);
        nxt();
        idle();
        mid();
        chk("t5f_md_ready", 32'(md_ready), 32'd1);
        nxt();

        // 6: reset while r8 result is buffered and r8/r9 pending
        iss_valid = 1; iss_addr = 5'd8;
        nxt();
        iss_valid = 0; iss_addr = 0;
        md_valid = 1; md_addr = 5'd8; md_data = 32'h0000_0088;
        nxt();
        md_valid = 0; md_addr = 0; md_data = 0;
        reset = 1;
        mid();
        chk("t6r_rf_wr", 32'(rf_wr), 32'd0);
        chk("t6r_md_ready", 32'(md_ready), 32'd0);
        chk("t6r_pending", pending, 32'h0000_0300);
        nxt();
        reset = 0;
        mid();
        chk("t6a_pending", pending, 32'd0);
        chk("t6a_md_ready", 32'(md_ready), 32'd1);
        chk("t6a_rf_wr", 32'(rf_wr), 32'd0);
        nxt();
        for (int k = 0; k < 3; k++) begin
            mid();
            nxt();
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single RegFile write port (wr/addr3/data3) between two writers: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- Pipeline writeback has fixed priority and no backpressure.
- MDU results go through a 1-entry holding buffer with a valid/ready handshake.
- A 32-bit scoreboard tracks registers with outstanding MDU results, flags read/write hazards for decode, and raises a pipeline stall request when the MDU result is starved.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a buffered MDU result may lose the port before stall_req asserts (range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- wb_wr  input  1  pipeline writeback request, valid this cycle only
- wb_addr  input  5  pipeline destination register
- wb_data  input  32  pipeline writeback data
- md_valid  input  1  MDU result valid
- md_addr  input  5  MDU destination register
- md_data  input  32  MDU result data
- md_ready  output  1  holding buffer can accept an MDU result
- iss_valid  input  1  MDU op issued this cycle
- iss_addr  input  5  destination register of the issued MDU op
- rs_addr  input  5  decode source register 1 to check
- rt_addr  input  5  decode source register 2 to check
- rd_addr  input  5  decode destination register to check
- hazard  output  1  any of rs/rt/rd is pending
- stall_req  output  1  pipeline must insert a writeback bubble
- pending  output  32  scoreboard vector; bit 0 is always 0
- rf_wr  output  1  to RegFile wr
- rf_addr  output  5  to RegFile addr3
- rf_data  output  32  to RegFile data3

Behaviour:
- Reset (synchronous, sampled at rising clk):
  - buf_vld=0, pending=0, starve_cnt=0, stall_req=0.
  - While reset is high, rf_wr=0 and md_ready=0 (combinational gating).
- Handshake:
  - md_ready = ~buf_vld & ~reset.
  - On md_valid & md_ready, the buffer captures md_addr/md_data and buf_vld=1 the next cycle.
  - The MDU holds md_* stable until accepted.
  - md_ready does not depend on md_valid.
- Port select (combinational, same cycle):
  - If wb_wr & wb_addr!=0: rf_wr=1, rf_addr=wb_addr, rf_data=wb_data (WB wins).
  - Else if buf_vld & buf_addr!=0: rf_wr=1, rf_addr/rf_data from the buffer; buf_vld clears at the next edge.
  - Else if buf_vld & buf_addr==0: rf_wr=0; the entry is discarded (buf_vld clears) with no pending clear.
  - Else rf_wr=0, rf_addr=0, rf_data=0.
  - wb_wr with wb_addr==0 counts as no request.
- Latency:
  - MDU handshake cycle N gives rf_wr in cycle N+1 at the earliest.
  - The buffer refills at the earliest in cycle N+2, after the drain cycle (no bypass).
- Scoreboard:
  - iss_valid & iss_addr!=0 sets pending[iss_addr].
  - A buffer write to the RegFile clears pending[buf_addr].
  - Set and clear of the same bit in one cycle: set wins.
  - pending[0] is hard 0.
  - hazard = pending[rs_addr] | pending[rt_addr] | pending[rd_addr] (combinational, current-cycle state, no bypass of this cycle's clear).
- Starvation:
  - starve_cnt increments each cycle buf_vld=1 and WB owns the port (saturating).
  - It resets to 0 when the buffer drains or buf_vld=0.
  - stall_req is registered: it sets at the edge where starve_cnt reaches STARVE_LIMIT-1 while still starved, and clears at the edge after the buffer drains.
- Pipeline contract: wb_wr=0 in every cycle stall_req=1. If violated, WB still wins; no pipeline data is ever dropped.
- Reset mid-operation: the buffered MDU result is lost and pending is cleared. The MDU and pipeline are reset together.
- Protocol errors (not required to be handled):
  - iss_valid to an already pending register: the bit stays 1.
  - md_valid for a non-pending address: written normally.

Test Plan:
1. Reset asserted for 2 cycles with md_valid=1 and wb_wr=1 -> rf_wr=0, md_ready=0, pending=0, stall_req=0; the first cycle after release md_ready=1.
2. iss_valid, iss_addr=5 in cycle 0; md_valid, md_addr=5, md_data=0x12345678 in cycle 3, no wb_wr -> pending[5]=1 in cycles 1-4, rf_wr=1 with rf_addr=5 and rf_data=0x12345678 in cycle 4, pending[5]=0 in cycle 5; hazard=1 for rs_addr=5 in cycles 1-4.
3. Buffer holds addr 7 while wb_wr=1 (addr 3, data 0xA) -> WB data written each cycle, md_ready=0; after 4 starved cycles (STARVE_LIMIT=4) stall_req=1. Bench drops wb_wr -> buffer written the next cycle, stall_req=0 the cycle after.
4. Same-cycle iss_valid addr 9 and buffer drain of addr 9 -> pending[9] remains 1.
5. md_valid with md_addr=0 -> accepted, no rf_wr, buf_vld clears, pending unchanged; wb_wr with wb_addr=0 lets a buffered addr-4 entry write that cycle.
6. Reset asserted while buf_vld=1 and pending=0x00000300 -> next cycle buf_vld=0 and pending=0; the dropped result never reaches rf_wr.
